shadow_err_collector: RTL

SHADOW_ERR_COLLECTOR -- requirements
Module: shadow_err_collector

---
 rtl/shadow_err_collector.sv | 116 +++++++++++
 1 files changed

// File: rtl/shadow_err_collector.sv
// Collects update/storage mismatch errors from shadowed registers into sticky status
// and drives two independent 4-phase alert handshakes. Define SHADOW_ERR_CNT_EN to add recov_cnt_o.
module shadow_err_collector #(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned CntW    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumRegs-1:0] err_update_i,
  input  logic [NumRegs-1:0] err_storage_i,
  input  logic [NumRegs-1:0] clr_recov_i,
  output logic [NumRegs-1:0] recov_status_o,
  output logic [NumRegs-1:0] fatal_status_o,
  output logic               recov_req_o,
  input  logic               recov_ack_i,
  output logic               fatal_req_o,
  input  logic               fatal_ack_i,
  output logic [CntW-1:0]    recov_cnt_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StWaitLow = 2'd2;

  logic [NumRegs-1:0] recov_status_q, recov_status_d;
  logic [NumRegs-1:0] fatal_status_q, fatal_status_d;
  logic               recov_pending_q, recov_pending_d;
  logic               any_update;
  logic [1:0]         trig, ack, go, req;

  assign any_update = |err_update_i;

  // A new event in the same cycle the channel accepts the old one keeps pending set,
  // so it is signalled by a later handshake rather than lost.
  always_comb begin
    recov_status_d  = (recov_status_q & ~clr_recov_i) | err_update_i;
    fatal_status_d  = fatal_status_q | err_storage_i;
    recov_pending_d = any_update | (recov_pending_q & ~go[0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recov_status_q  <= '0;
      fatal_status_q  <= '0;
      recov_pending_q <= 1'b0;
    end else begin
      recov_status_q  <= recov_status_d;
      fatal_status_q  <= fatal_status_d;
      recov_pending_q <= recov_pending_d;
    end
  end

  assign trig = {|fatal_status_q, recov_pending_q};
  assign ack  = {fatal_ack_i, recov_ack_i};

  // Channel 0 is the recoverable alert, channel 1 the fatal alert.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [1:0] state_q, state_d;
    logic       req_q, req_d;

    // IDLE only leaves with ack low, so a stale ack can never complete a fresh request.
    assign go[gi] = (state_q == StIdle) && trig[gi] && !ack[gi];

    always_comb begin
      state_d = state_q;
      case (state_q)
        StIdle:    if (go[gi])   state_d = StReq;
        StReq:     if (ack[gi])  state_d = StWaitLow;
        StWaitLow: if (!ack[gi]) state_d = StIdle;
        default:                 state_d = StIdle;
      endcase
      req_d = (state_d == StReq);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StIdle;
        req_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
      end
    end

    assign req[gi] = req_q;
  end

  assign recov_req_o    = req[0];
  assign fatal_req_o    = req[1];
  assign recov_status_o = recov_status_q;
  assign fatal_status_o = fatal_status_q;

`ifdef SHADOW_ERR_CNT_EN
  logic [CntW-1:0] recov_cnt_q, recov_cnt_d;

  always_comb begin
    recov_cnt_d = recov_cnt_q;
    if (any_update && (recov_cnt_q != {CntW{1'b1}})) begin
      recov_cnt_d = recov_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      recov_cnt_q <= '0;
    end else begin
      recov_cnt_q <= recov_cnt_d;
    end
  end

  assign recov_cnt_o = recov_cnt_q;
`else
  assign recov_cnt_o = '0;
`endif

endmodule
